// File: rtl/vx_perf_memsys_reader.sv
// Memory-system perf counter reader: snapshots 15 live counters into a shadow bank and serves 32-bit lo/hi reads.
// Optional: define VX_PERF_MEMSYS_DELTA_EN to make each snapshot hold the delta since the previous snapshot.
module vx_perf_memsys_reader #(
    parameter int PERF_CTR_BITS = 44,
    parameter int NUM_CTRS      = 15,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_CTRS*PERF_CTR_BITS-1:0] ctr_in,
    input  logic                              snap,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [3:0]                        req_idx,
    input  logic                              req_hi,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [DATA_WIDTH-1:0]             rsp_data,
    output logic                              rsp_err,
    output logic [15:0]                       snap_cnt
);

    localparam int HI_BITS = PERF_CTR_BITS - 32;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t state;
    state_t state_next;
    logic   accept;

    logic [PERF_CTR_BITS-1:0] live    [NUM_CTRS];
    logic [PERF_CTR_BITS-1:0] cap_val [NUM_CTRS];
    logic [PERF_CTR_BITS-1:0] shadow  [NUM_CTRS];

    logic [PERF_CTR_BITS-1:0] sel_val;
    logic [DATA_WIDTH-1:0]    rd_word;
    logic                     idx_ok;

    always_comb begin
        for (int i = 0; i < NUM_CTRS; i++) begin
            live[i] = ctr_in[i*PERF_CTR_BITS +: PERF_CTR_BITS];
        end
    end

`ifdef VX_PERF_MEMSYS_DELTA_EN
    logic [PERF_CTR_BITS-1:0] prev [NUM_CTRS];

    // Modular subtraction gives the correct delta even across a counter wrap.
    always_comb begin
        for (int i = 0; i < NUM_CTRS; i++) begin
            cap_val[i] = live[i] - prev[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CTRS; i++) begin
                prev[i] <= '0;
            end
        end else if (snap) begin
            for (int i = 0; i < NUM_CTRS; i++) begin
                prev[i] <= live[i];
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_CTRS; i++) begin
            cap_val[i] = live[i];
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CTRS; i++) begin
                shadow[i] <= '0;
            end
        end else if (snap) begin
            for (int i = 0; i < NUM_CTRS; i++) begin
                shadow[i] <= cap_val[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_cnt <= '0;
        end else if (snap) begin
            snap_cnt <= snap_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A snap coinciding with the accept must return the value being captured, not the stale shadow.
    always_comb begin
        sel_val = '0;
        idx_ok  = 1'b0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            if (req_idx == 4'(i)) begin
                idx_ok  = 1'b1;
                sel_val = snap ? cap_val[i] : shadow[i];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (req_hi) begin
            rd_word[HI_BITS-1:0] = sel_val[PERF_CTR_BITS-1:32];
        end else begin
            rd_word[31:0] = sel_val[31:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (accept) begin
            rsp_data <= rd_word;
            rsp_err  <= ~idx_ok;
        end
    end

endmodule

// File: tb/tb_vx_perf_memsys_reader.sv
// Scoreboard bench for vx_perf_memsys_reader: directed reads push expected words, a negedge monitor pops and compares.
module tb_vx_perf_memsys_reader;

    localparam int PCB = 44;
    localparam int NC  = 15;

`ifdef VX_PERF_MEMSYS_DELTA_EN
    localparam logic [31:0] EXP_RESNAP_LO = 32'hBA98765A;
    localparam logic [31:0] EXP_HOLD_END  = 32'h00000001;
    localparam logic [31:0] EXP_WRAP_LO   = 32'h00000020;
`else
    localparam logic [31:0] EXP_RESNAP_LO = 32'h00000005;
    localparam logic [31:0] EXP_HOLD_END  = 32'h00000104;
    localparam logic [31:0] EXP_WRAP_LO   = 32'h00000010;
`endif

    logic              clk;
    logic              reset_n;
    logic [NC*PCB-1:0] ctr_in;
    logic              snap;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_idx;
    logic              req_hi;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic [15:0]       snap_cnt;

    int          tests;
    int          failed;
    int          exp_snap_cnt;
    logic [32:0] exp_q[$];

    vx_perf_memsys_reader #(
        .PERF_CTR_BITS(PCB),
        .NUM_CTRS     (NC),
        .DATA_WIDTH   (32)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ctr_in   (ctr_in),
        .snap     (snap),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_idx  (req_idx),
        .req_hi   (req_hi),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .snap_cnt (snap_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Responses are consumed on the following posedge, so the negedge view is stable and unambiguous.
    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_rsp", 64'(rsp_data), 64'hDEAD_0000_0000);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check_output("rsp_data", 64'(rsp_data), 64'(e[31:0]));
                check_output("rsp_err", 64'(rsp_err), 64'(e[32]));
            end
        end
    end

    task automatic set_ctr(input int idx, input logic [63:0] val);
        ctr_in[idx*PCB +: PCB] = val[PCB-1:0];
    endtask

    task automatic pulse_snap();
        snap = 1'b1;
        exp_snap_cnt++;
        @(posedge clk); #1;
        snap = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [3:0] idx, input logic hi, input logic with_snap,
                                  input logic [31:0] exp_data, input logic exp_err, input string name);
        check_output({name, "_req_ready"}, 64'(req_ready), 64'd1);
        check_output({name, "_idle_valid"}, 64'(rsp_valid), 64'd0);
        req_valid = 1'b1;
        req_idx   = idx;
        req_hi    = hi;
        snap      = with_snap;
        if (with_snap) exp_snap_cnt++;
        exp_q.push_back({exp_err, exp_data});
        @(posedge clk); #1;
        req_valid = 1'b0;
        snap      = 1'b0;
        check_output({name, "_latency"}, 64'(rsp_valid), 64'd1);
        if (rsp_ready) begin
            @(posedge clk); #1;
            check_output({name, "_done"}, 64'(rsp_valid), 64'd0);
        end
    endtask

    initial begin
        tests        = 0;
        failed       = 0;
        exp_snap_cnt = 0;
        clk          = 1'b0;
        reset_n      = 1'b0;
        ctr_in       = '0;
        snap         = 1'b0;
        req_valid    = 1'b0;
        req_idx      = '0;
        req_hi       = 1'b0;
        rsp_ready    = 1'b1;

        #2;
        check_output("reset_req_ready", 64'(req_ready), 64'd1);
        check_output("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("reset_rsp_data", 64'(rsp_data), 64'd0);
        check_output("reset_snap_cnt", 64'(snap_cnt), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic capture and lo/hi split
        set_ctr(2, 64'h123_4567_89AB);
        pulse_snap();
        check_output("snap_cnt_first", 64'(snap_cnt), 64'(exp_snap_cnt));
        apply_stimulus(4'd2, 1'b0, 1'b0, 32'h456789AB, 1'b0, "idx2_lo");
        apply_stimulus(4'd2, 1'b1, 1'b0, 32'h00000123, 1'b0, "idx2_hi");

        // Shadow is frozen until the next snapshot
        set_ctr(2, 64'h5);
        apply_stimulus(4'd2, 1'b0, 1'b0, 32'h456789AB, 1'b0, "idx2_stale");
        pulse_snap();
        apply_stimulus(4'd2, 1'b0, 1'b0, EXP_RESNAP_LO, 1'b0, "idx2_resnap");

        apply_stimulus(4'd15, 1'b0, 1'b0, 32'h0, 1'b1, "idx15_err");

        // Backpressure with snapshots landing while the response is held
        rsp_ready = 1'b0;
        apply_stimulus(4'd2, 1'b0, 1'b0, EXP_RESNAP_LO, 1'b0, "hold");
        for (int k = 0; k < 5; k++) begin
            set_ctr(2, 64'h100 + 64'(k));
            snap = 1'b1;
            exp_snap_cnt++;
            check_output("hold_valid", 64'(rsp_valid), 64'd1);
            check_output("hold_req_ready", 64'(req_ready), 64'd0);
            check_output("hold_data", 64'(rsp_data), 64'(EXP_RESNAP_LO));
            @(posedge clk); #1;
        end
        snap = 1'b0;
        check_output("hold_data_after", 64'(rsp_data), 64'(EXP_RESNAP_LO));
        check_output("snap_cnt_hold", 64'(snap_cnt), 64'(exp_snap_cnt));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check_output("hold_release_valid", 64'(rsp_valid), 64'd0);
        check_output("hold_release_ready", 64'(req_ready), 64'd1);
        apply_stimulus(4'd2, 1'b0, 1'b0, EXP_HOLD_END, 1'b0, "idx2_after_hold");

        // Same-cycle snap and accept
        set_ctr(14, 64'h77);
        apply_stimulus(4'd14, 1'b0, 1'b1, 32'h00000077, 1'b0, "bypass14");
        check_output("snap_cnt_bypass", 64'(snap_cnt), 64'(exp_snap_cnt));

        // Counter near the top, then wrapped
        set_ctr(0, 64'hFFF_FFFF_FFF0);
        pulse_snap();
        apply_stimulus(4'd0, 1'b0, 1'b0, 32'hFFFFFFF0, 1'b0, "idx0_top_lo");
        apply_stimulus(4'd0, 1'b1, 1'b0, 32'h00000FFF, 1'b0, "idx0_top_hi");
        set_ctr(0, 64'h10);
        pulse_snap();
        apply_stimulus(4'd0, 1'b0, 1'b0, EXP_WRAP_LO, 1'b0, "idx0_wrap_lo");
        apply_stimulus(4'd0, 1'b1, 1'b0, 32'h0, 1'b0, "idx0_wrap_hi");

        pulse_snap();
        pulse_snap();
        check_output("snap_cnt_b2b", 64'(snap_cnt), 64'(exp_snap_cnt));

        // Reset while a response is pending
        rsp_ready = 1'b0;
        apply_stimulus(4'd3, 1'b0, 1'b0, 32'h0, 1'b0, "rst_pending");
        #3;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        exp_snap_cnt = 0;
        check_output("midrst_valid", 64'(rsp_valid), 64'd0);
        check_output("midrst_req_ready", 64'(req_ready), 64'd1);
        check_output("midrst_data", 64'(rsp_data), 64'd0);
        check_output("midrst_snap_cnt", 64'(snap_cnt), 64'd0);
        @(posedge clk); #1;
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_output("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        apply_stimulus(4'd2, 1'b0, 1'b0, 32'h0, 1'b0, "post_rst_shadow");

        repeat (2) @(posedge clk);
        #1;
        check_output("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
